// File: rtl/cond_pkg.sv
// cond_pkg: condition-code constants, resolver FSM states and condition helpers
// shared by the conditional branch unit.
package cond_pkg;
  localparam logic [2:0] COND_B  = 3'd0;
  localparam logic [2:0] COND_EQ = 3'd1;
  localparam logic [2:0] COND_NE = 3'd2;
  localparam logic [2:0] COND_LT = 3'd3;
  localparam logic [2:0] COND_LE = 3'd4;
  typedef enum logic [1:0] {IDLE, WAIT, EVAL} state_e;
  function automatic logic cond_met(input logic [2:0] c, input logic z, input logic n, input logic v);
    return c == COND_B  ? 1'b1 :
           c == COND_EQ ? z :
           c == COND_NE ? !z :
           c == COND_LT ? n ^ v :
           c == COND_LE ? (n ^ v) | z : 1'b0;
  endfunction
  function automatic logic cond_legal(input logic [2:0] c);
    return c <= COND_LE;
  endfunction
endpackage

// File: rtl/cond_branch_unit_if.sv
// cond_branch_unit_if: branch resolve request/acknowledge bus between
// the requester (master) and the branch unit (slave).
interface cond_branch_unit_if #(
  parameter int PC_W = 9
);
  logic            br_req;
  logic [2:0]      br_cond;
  logic [PC_W-1:0] pc;
  logic [15:0]     sximm8;
  logic            br_ack;
  logic            taken;
  logic [PC_W-1:0] next_pc;
  logic            err;
  modport master (output br_req, br_cond, pc, sximm8, input br_ack, taken, next_pc, err);
  modport slave  (input br_req, br_cond, pc, sximm8, output br_ack, taken, next_pc, err);
endinterface

// File: rtl/cond_branch_unit_status_reg.sv
// status_reg: Z/N/V status flags, loaded from the ALU when loads is high.
module status_reg (
  input  logic clk,
  input  logic reset,
  input  logic loads,
  input  logic Z_in,
  input  logic N_in,
  input  logic ovf_in,
  output logic Z,
  output logic N,
  output logic V
);
  logic [2:0] flags_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) flags_q <= '0;
    else if (loads) flags_q <= {Z_in, N_in, ovf_in};
  assign {Z, N, V} = flags_q;
endmodule

// File: rtl/cond_branch_unit.sv
// cond_branch_unit: resolves conditional branches against the registered ALU flags.
// Define COND_BRANCH_ILLEGAL_TRAP_EN to raise err on illegal condition codes.
module cond_branch_unit
  import cond_pkg::*;
#(
  parameter int PC_W = 9
) (
  input  logic clk,
  input  logic reset,
  input  logic Z_in,
  input  logic N_in,
  input  logic ovf_in,
  input  logic loads,
  input  logic flag_pend,
  output logic Z,
  output logic N,
  output logic V,
  cond_branch_unit_if.slave br
);
  state_e          state_q, state_d;
  logic            taken_q, taken_d, err_q, err_d, stall;
  logic [PC_W-1:0] next_pc_q, next_pc_d;
  status_reg u_status (.clk, .reset, .loads, .Z_in, .N_in, .ovf_in, .Z, .N, .V);
  assign stall     = flag_pend | loads;
  assign taken_d   = cond_met(br.br_cond, Z, N, V);
  assign next_pc_d = br.pc + PC_W'(1) + (taken_d ? br.sximm8[PC_W-1:0] : '0);
`ifdef COND_BRANCH_ILLEGAL_TRAP_EN
  assign err_d = !cond_legal(br.br_cond);
`else
  assign err_d = 1'b0;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  always_comb
    state_d = state_q == IDLE ? (br.br_req ? (stall ? WAIT : EVAL) : IDLE) :
              state_q == WAIT ? (stall ? WAIT : EVAL) : IDLE;
  // Result is captured on entry to EVAL, so flag loads during EVAL cannot disturb it
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      taken_q   <= 1'b0;
      next_pc_q <= '0;
      err_q     <= 1'b0;
    end else if (state_d == EVAL) begin
      taken_q   <= taken_d;
      next_pc_q <= next_pc_d;
      err_q     <= err_d;
    end
  always_comb begin
    br.br_ack  = state_q == EVAL;
    br.taken   = taken_q;
    br.next_pc = next_pc_q;
    br.err     = err_q;
  end
endmodule

// File: tb/tb_cond_branch_unit.sv
// tb_cond_branch_unit: randomized self-checking bench for cond_branch_unit
// against a flag/branch reference model kept in the bench.
module tb_cond_branch_unit;
  logic clk = 1'b0, reset = 1'b1;
  logic z_in = 0, n_in = 0, ovf_in = 0, loads = 0, flag_pend = 0;
  logic z_o, n_o, v_o;
  int n_checks = 0, n_fail = 0;
  logic mz = 0, mn = 0, mv = 0;
  cond_branch_unit_if #(.PC_W(9)) bus ();
  cond_branch_unit #(.PC_W(9)) dut (
    .clk(clk), .reset(reset), .Z_in(z_in), .N_in(n_in), .ovf_in(ovf_in),
    .loads(loads), .flag_pend(flag_pend), .Z(z_o), .N(n_o), .V(v_o), .br(bus)
  );
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic model_taken(input logic [2:0] c);
    case (c)
      3'd0: return 1'b1;
      3'd1: return mz;
      3'd2: return !mz;
      3'd3: return mn != mv;
      3'd4: return (mn != mv) || mz;
      default: return 1'b0;
    endcase
  endfunction

  task automatic load_flags(input logic z, input logic n, input logic v);
    loads = 1; {z_in, n_in, ovf_in} = {z, n, v};
    @(posedge clk);
    {mz, mn, mv} = {z, n, v};
    #1 loads = 0; {z_in, n_in, ovf_in} = 3'($urandom);
    @(negedge clk);
    chk("flags", {z_o, n_o, v_o}, {mz, mn, mv});
  endtask

  task automatic do_branch(input logic [2:0] c, input logic [8:0] p, input logic [15:0] off,
                           input int pend, input logic ld, input logic [2:0] ldv,
                           input logic ld_eval, input logic keep, input int extra);
    int n = 0, exp_lat, pc_sum;
    logic got = 0, exp_t, exp_e;
    logic [8:0] exp_pc;
    bus.br_req = 1; bus.br_cond = c; bus.pc = p; bus.sximm8 = off;
    flag_pend = pend > 0; loads = ld;
    {z_in, n_in, ovf_in} = ld ? ldv : 3'($urandom);
    exp_lat = (pend > int'(ld) ? pend : int'(ld)) + 1 + extra;
    while (!got && n < 20) begin
      @(posedge clk);
      n++;
      if (loads) {mz, mn, mv} = {z_in, n_in, ovf_in};
      #1 loads = 0; {z_in, n_in, ovf_in} = 3'($urandom);
      if (pend > 0) pend--;
      flag_pend = pend > 0;
      @(negedge clk);
      got = bus.br_ack;
    end
    if (!got) chk("ack_timeout", 0, 1);
    exp_t = model_taken(c);
    pc_sum = (int'(p) + 1 + (exp_t ? int'(off) : 0)) % 512;
    exp_pc = 9'(pc_sum);
`ifdef COND_BRANCH_ILLEGAL_TRAP_EN
    exp_e = c > 3'd4;
`else
    exp_e = 1'b0;
`endif
    chk("latency", n, exp_lat);
    chk("taken", bus.taken, exp_t);
    chk("next_pc", bus.next_pc, exp_pc);
    chk("err", bus.err, exp_e);
    if (keep) return;
    bus.br_req = 0;
    if (ld_eval) begin
      loads = 1; {z_in, n_in, ovf_in} = 3'($urandom);
    end
    @(posedge clk);
    if (loads) {mz, mn, mv} = {z_in, n_in, ovf_in};
    #1 loads = 0;
    @(negedge clk);
    chk("ack_pulse", bus.br_ack, 0);
    chk("hold", {bus.err, bus.taken, bus.next_pc}, {exp_e, exp_t, exp_pc});
    chk("flags_after", {z_o, n_o, v_o}, {mz, mn, mv});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.br_req = 0; bus.br_cond = 0; bus.pc = 0; bus.sximm8 = 0;
    z_in = 1; n_in = 1; ovf_in = 1; loads = 1;
    repeat (2) @(negedge clk);
    chk("rst_out", {bus.br_ack, bus.taken, bus.err, bus.next_pc}, 0);
    chk("rst_flags", {z_o, n_o, v_o}, 0);
    loads = 0;
    reset = 0;
    @(negedge clk);
    load_flags(1, 0, 0);
    do_branch(3'd1, 9'd10, 16'd5, 0, 0, 0, 0, 0, 0);
    load_flags(0, 1, 0);
    do_branch(3'd3, 9'd77, 16'd20, 3, 0, 0, 0, 0, 0);
    load_flags(0, 0, 0);
    do_branch(3'd2, 9'd511, 16'hFFFF, 0, 0, 0, 0, 0, 0);
    do_branch(3'd1, 9'd511, 16'd3, 0, 0, 0, 0, 0, 0);
    load_flags(1, 0, 0);
    do_branch(3'd1, 9'd40, 16'd8, 0, 1, 3'b000, 0, 0, 0);
    do_branch(3'd6, 9'd100, 16'd9, 0, 0, 0, 0, 0, 0);
    do_branch(3'd0, 9'd200, 16'd12, 0, 0, 0, 1, 0, 0);
    do_branch(3'd0, 9'd300, 16'd1, 0, 0, 0, 0, 1, 0);
    do_branch(3'd4, 9'd301, 16'hFFFE, 0, 0, 0, 0, 0, 1);
    load_flags(1, 1, 1);
    bus.br_req = 1; bus.br_cond = 3'd0; flag_pend = 1;
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1;
    #1 {mz, mn, mv} = 3'b000;
    chk("rst_wait_out", {bus.br_ack, bus.taken, bus.err, bus.next_pc}, 0);
    chk("rst_wait_flags", {z_o, n_o, v_o}, 0);
    bus.br_req = 0; flag_pend = 0;
    @(negedge clk);
    reset = 0;
    repeat (3) begin
      @(negedge clk);
      chk("no_ack", bus.br_ack, 0);
    end
    do_branch(3'd2, 9'd5, 16'd7, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(3) == 0) load_flags(1'($urandom), 1'($urandom), 1'($urandom));
      do_branch(3'($urandom), 9'($urandom), ($urandom_range(1) == 1) ? 16'($urandom) : 16'($urandom_range(31)),
                int'($urandom_range(3)), 1'($urandom), 3'($urandom), 1'($urandom), 0, 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
